// File: rtl/pit_top_level_if.sv
// Bus bundle for the interval timer: direction control in, count and wrap indicator out.
interface pit_top_level_if;
  logic       DIRECTION;
  logic [3:0] COUNT;
  logic       LED;

  modport master (output DIRECTION, input COUNT, input LED);
  modport slave  (input DIRECTION, output COUNT, output LED);
endinterface

// File: rtl/pit_top_level.sv
// Programmable interval timer: prescaler feeding a 4-bit up/down counter with wrap indicator.
// Optional macro PIT_LED_PULSE_EN turns LED from a wrap toggle into a one-cycle wrap pulse.
module pit_top_level #(
  parameter int PRESCALE = 4
) (
  input  logic            CLOCK,
  input  logic            RST,
  pit_top_level_if.slave  bus
);

  localparam int PreWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreWidth-1:0] PreLast = PreWidth'(PRESCALE - 1);

  logic [PreWidth-1:0] pre_q, pre_d;
  logic [3:0]          count_q, count_d;
  logic                led_q, led_d;
  logic                tick;
  logic                wrap;

  assign tick = (pre_q == PreLast);

  // A wrap is a step that crosses the 15/0 boundary in the sampled direction.
  always_comb begin
    wrap = 1'b0;
    if (tick) begin
      if (bus.DIRECTION) wrap = (count_q == 4'd15);
      else               wrap = (count_q == 4'd0);
    end
  end

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PreWidth'(1);
    count_d = count_q;
    if (tick) begin
      if (bus.DIRECTION) count_d = count_q + 4'd1;
      else               count_d = count_q - 4'd1;
    end
`ifdef PIT_LED_PULSE_EN
    led_d = wrap;
`else
    led_d = led_q ^ wrap;
`endif
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      pre_q   <= '0;
      count_q <= 4'd0;
      led_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.LED   = led_q;

endmodule

// File: tb/tb_pit_top_level.sv
// Directed self-checking bench: one DUT at PRESCALE=4 and one at PRESCALE=1.
module tb_pit_top_level;

  logic CLOCK = 1'b0;
  logic rst4  = 1'b1;
  logic rst1  = 1'b1;
  int   passCount  = 0;
  int   checkCount = 0;

  pit_top_level_if if4 ();
  pit_top_level_if if1 ();

  pit_top_level #(.PRESCALE(4)) dut4 (.CLOCK(CLOCK), .RST(rst4), .bus(if4.slave));
  pit_top_level #(.PRESCALE(1)) dut1 (.CLOCK(CLOCK), .RST(rst1), .bus(if1.slave));

  always #5 CLOCK = ~CLOCK;

`ifdef PIT_LED_PULSE_EN
  localparam bit PulseMode = 1'b1;
`else
  localparam bit PulseMode = 1'b0;
`endif

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic reset4(input int n, input logic dirAfter);
    rst4 = 1'b1;
    repeat (n) step();
    rst4 = 1'b0;
    if4.DIRECTION = dirAfter;
  endtask

  task automatic reset1(input int n, input logic dirAfter);
    rst1 = 1'b1;
    repeat (n) step();
    rst1 = 1'b0;
    if1.DIRECTION = dirAfter;
  endtask

  task automatic test_reset();
    logic [3:0] expCount;
    rst4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if4.DIRECTION = 1'($urandom);
      step();
      checkCount++;
      if (if4.COUNT !== 4'd0 || if4.LED !== 1'b0)
        $display("FAIL reset_hold cycle %0d: COUNT=%0d LED=%0b, required COUNT=0 LED=0", i, if4.COUNT, if4.LED);
      else passCount++;
    end
    rst4 = 1'b0;
    if4.DIRECTION = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      expCount = 4'(e / 4);
      checkCount++;
      if (if4.COUNT !== expCount)
        $display("FAIL reset_release edge %0d: COUNT=%0d, required %0d", e, if4.COUNT, expCount);
      else passCount++;
    end
  endtask

  task automatic test_down_from_reset();
    logic [3:0] expCount;
    logic       expLed;
    reset4(2, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      step();
      expCount = 4'(16 - e / 4);
      if (PulseMode) expLed = (e == 4);
      else           expLed = (e >= 4);
      checkCount++;
      if (if4.COUNT !== expCount || if4.LED !== expLed)
        $display("FAIL down_from_reset edge %0d: COUNT=%0d LED=%0b, required COUNT=%0d LED=%0b",
                 e, if4.COUNT, if4.LED, expCount, expLed);
      else passCount++;
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] expCount;
    logic       expLed;
    reset1(1, 1'b1);
    for (int e = 1; e <= 32; e++) begin
      step();
      expCount = 4'(e % 16);
      if (PulseMode) expLed = (e == 16 || e == 32);
      else           expLed = (e >= 16 && e < 32);
      checkCount++;
      if (if1.COUNT !== expCount || if1.LED !== expLed)
        $display("FAIL up_wrap cycle %0d: COUNT=%0d LED=%0b, required COUNT=%0d LED=%0b",
                 e, if1.COUNT, if1.LED, expCount, expLed);
      else passCount++;
    end
  endtask

  task automatic test_direction_change();
    logic [3:0] expCount;
    reset4(1, 1'b1);
    repeat (20) step();
    checkCount++;
    if (if4.COUNT !== 4'd5)
      $display("FAIL dir_change_setup: COUNT=%0d, required 5", if4.COUNT);
    else passCount++;
    for (int e = 21; e <= 28; e++) begin
      step();
      if (e == 21) if4.DIRECTION = 1'b0;
      if (e == 25) if4.DIRECTION = 1'b1;
      if (e == 26) if4.DIRECTION = 1'b0;
      if      (e < 24) expCount = 4'd5;
      else if (e < 28) expCount = 4'd4;
      else             expCount = 4'd3;
      checkCount++;
      if (if4.COUNT !== expCount)
        $display("FAIL dir_change edge %0d: COUNT=%0d, required %0d", e, if4.COUNT, expCount);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] expCount;
    reset4(1, 1'b0);
    repeat (28) step();
    checkCount++;
    if (if4.COUNT !== 4'd9 || if4.LED !== !PulseMode)
      $display("FAIL reset_mid_setup: COUNT=%0d LED=%0b, required COUNT=9 LED=%0b",
               if4.COUNT, if4.LED, !PulseMode);
    else passCount++;
    repeat (3) step();
    rst4 = 1'b1;
    step();
    checkCount++;
    if (if4.COUNT !== 4'd0 || if4.LED !== 1'b0)
      $display("FAIL reset_mid_tick: COUNT=%0d LED=%0b, required COUNT=0 LED=0", if4.COUNT, if4.LED);
    else passCount++;
    rst4 = 1'b0;
    if4.DIRECTION = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      expCount = (e == 4) ? 4'd1 : 4'd0;
      checkCount++;
      if (if4.COUNT !== expCount)
        $display("FAIL reset_mid_release edge %0d: COUNT=%0d, required %0d", e, if4.COUNT, expCount);
      else passCount++;
    end
  endtask

  task automatic test_boundary_reversal();
    reset1(1, 1'b1);
    repeat (15) step();
    checkCount++;
    if (if1.COUNT !== 4'd15 || if1.LED !== 1'b0)
      $display("FAIL boundary_setup: COUNT=%0d LED=%0b, required COUNT=15 LED=0", if1.COUNT, if1.LED);
    else passCount++;
    if1.DIRECTION = 1'b0;
    step();
    checkCount++;
    if (if1.COUNT !== 4'd14 || if1.LED !== 1'b0)
      $display("FAIL boundary_reverse: COUNT=%0d LED=%0b, required COUNT=14 LED=0", if1.COUNT, if1.LED);
    else passCount++;
  endtask

  initial begin
    if4.DIRECTION = 1'b0;
    if1.DIRECTION = 1'b0;
    rst1 = 1'b1;
    test_reset();
    test_down_from_reset();
    test_up_wrap();
    test_direction_change();
    test_reset_mid();
    test_boundary_reversal();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
